// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: shared trap encodings and controller state encoding.
//   Exception codes are the shared encodings used by the commit stage and the
//   CSR file; EXCEPTION_NONE and the trap_ctrl states sit alongside them.
//   No ports (package).
package trap_ctrl_pkg;

  localparam int CODE_W = 6;
  localparam int CNT_W  = 8;

  localparam logic [CODE_W-1:0] EXCEPTION_NONE         = 6'h00;
  localparam logic [CODE_W-1:0] EXCEPTION_LOAD_FAULT   = 6'h05;
  localparam logic [CODE_W-1:0] EXCEPTION_ILLEGAL_INSN = 6'h12;
  localparam logic [CODE_W-1:0] EXCEPTION_ERET_M       = 6'h18;
  localparam logic [CODE_W-1:0] EXCEPTION_FENCE        = 6'h19;
  localparam logic [CODE_W-1:0] EXCEPTION_INTERRUPT    = 6'h20;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAIN = 3'd1,
    ST_ISSUE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_SLEEP = 3'd4
  } trap_state_e;

endpackage

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: commit-stage / CSR-file side signals of the trap controller.
//   master : commit stage + CSR file (drives requests, consumes trap outputs)
//   slave  : trap_ctrl
//   Requests : exc_valid_i, exc_code_i[5:0], exc_pc_i[31:0], exc_addr_i[31:0],
//              intr_pending_i[31:0], next_pc_i[31:0], pipe_idle_i, wfi_i
//   Outputs  : stall_o, flush_o, exception_o[5:0], exception_pc_o[31:0],
//              exception_addr_o[31:0], busy_o
interface trap_ctrl_if;
  logic        exc_valid_i;
  logic [5:0]  exc_code_i;
  logic [31:0] exc_pc_i;
  logic [31:0] exc_addr_i;
  logic [31:0] intr_pending_i;
  logic [31:0] next_pc_i;
  logic        pipe_idle_i;
  logic        wfi_i;
  logic        stall_o;
  logic        flush_o;
  logic [5:0]  exception_o;
  logic [31:0] exception_pc_o;
  logic [31:0] exception_addr_o;
  logic        busy_o;

  modport master (
    output exc_valid_i, exc_code_i, exc_pc_i, exc_addr_i, intr_pending_i,
           next_pc_i, pipe_idle_i, wfi_i,
    input  stall_o, flush_o, exception_o, exception_pc_o, exception_addr_o, busy_o
  );

  modport slave (
    input  exc_valid_i, exc_code_i, exc_pc_i, exc_addr_i, intr_pending_i,
           next_pc_i, pipe_idle_i, wfi_i,
    output stall_o, flush_o, exception_o, exception_pc_o, exception_addr_o, busy_o
  );
endinterface

// File: rtl/trap_ctrl_cnt.sv
// trap_ctrl_cnt: loadable up/down counter shared by the DRAIN and HOLD phases.
//   clk_i, rstn_i        : clock, asynchronous active-low reset
//   load_i, load_val_i   : synchronous load (highest priority)
//   inc_i, dec_i         : increment / decrement (inc wins over dec)
//   cnt_o                : current count
module trap_ctrl_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_o <= '0;
    end else if (load_i) begin
      cnt_o <= load_val_i;
    end else if (inc_i) begin
      cnt_o <= cnt_o + 1'b1;
    end else if (dec_i) begin
      cnt_o <= cnt_o - 1'b1;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences exceptions, interrupts, MRET and FENCE into the CSR file.
//   Captures one request, stalls the front end, waits for the pipeline to
//   drain (bounded by DRAIN_MAX), issues code/PC/address with flush for one
//   cycle, then holds off new requests for HOLDOFF cycles.
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   bus (slave)   : request inputs from commit stage, trap outputs to CSR file
//   Optional macro TRAP_CTRL_WFI_EN: wfi_i puts the controller in SLEEP until
//   an interrupt is pending; without it wfi_i is ignored.
//
//   state | meaning
//   IDLE  | accepting requests, outputs quiet
//   DRAIN | request captured, front end stalled, waiting for pipe_idle_i
//   ISSUE | one cycle: code/PC/addr to CSR file, flush asserted
//   HOLD  | settle period of HOLDOFF cycles before returning to IDLE
//   SLEEP | WFI wait for a pending interrupt (TRAP_CTRL_WFI_EN only)
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int HOLDOFF   = 2,
  parameter int DRAIN_MAX = 64
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  trap_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_MAX - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLDOFF - 1);

  trap_state_e       state_q;
  logic [CODE_W-1:0] cap_code_q;
  logic [31:0]       cap_pc_q;
  logic [31:0]       cap_addr_q;
  logic              cap_intr_q;
  logic              stall_q;
  logic              flush_q;
  logic              busy_q;
  logic [CODE_W-1:0] exc_q;
  logic [31:0]       exc_pc_q;
  logic [31:0]       exc_addr_q;

  logic             intr_any;
  logic             drain_done;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_inc;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt;

  assign intr_any   = |bus.intr_pending_i;
  assign drain_done = bus.pipe_idle_i || (cnt == DRAIN_LAST);

  // Counter parks at 0 outside DRAIN/HOLD so every DRAIN starts from zero.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_inc      = 1'b0;
    cnt_dec      = 1'b0;
    case (state_q)
      ST_DRAIN: cnt_inc = !drain_done;
      ST_ISSUE: begin
        cnt_load     = 1'b1;
        cnt_load_val = HOLD_LOAD;
      end
      ST_HOLD:  cnt_dec = (cnt != '0);
      default:  cnt_load = 1'b1;
    endcase
  end

  trap_ctrl_cnt #(.W(CNT_W)) u_cnt (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .inc_i      (cnt_inc),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      cap_code_q <= EXCEPTION_NONE;
      cap_pc_q   <= '0;
      cap_addr_q <= '0;
      cap_intr_q <= 1'b0;
      stall_q    <= 1'b0;
      flush_q    <= 1'b0;
      busy_q     <= 1'b0;
      exc_q      <= EXCEPTION_NONE;
      exc_pc_q   <= '0;
      exc_addr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A synchronous exception wins; a coincident interrupt stays
          // pending and is picked up again once the sequence finishes.
          if (bus.exc_valid_i) begin
            cap_code_q <= bus.exc_code_i;
            cap_pc_q   <= bus.exc_pc_i;
            cap_addr_q <= bus.exc_addr_i;
            cap_intr_q <= 1'b0;
            state_q    <= ST_DRAIN;
            stall_q    <= 1'b1;
            busy_q     <= 1'b1;
          end else if (intr_any) begin
            cap_code_q <= EXCEPTION_INTERRUPT;
            cap_pc_q   <= bus.next_pc_i;
            cap_addr_q <= '0;
            cap_intr_q <= 1'b1;
            state_q    <= ST_DRAIN;
            stall_q    <= 1'b1;
            busy_q     <= 1'b1;
          end
`ifdef TRAP_CTRL_WFI_EN
          else if (bus.wfi_i) begin
            state_q <= ST_SLEEP;
            stall_q <= 1'b1;
            busy_q  <= 1'b1;
          end
`endif
        end
        ST_DRAIN: begin
          if (drain_done) begin
            // An interrupt that vanished while draining is dropped silently.
            if (cap_intr_q && !intr_any) begin
              state_q <= ST_IDLE;
              stall_q <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              state_q    <= ST_ISSUE;
              flush_q    <= 1'b1;
              exc_q      <= cap_code_q;
              exc_pc_q   <= cap_pc_q;
              exc_addr_q <= cap_addr_q;
            end
          end
        end
        ST_ISSUE: begin
          state_q <= ST_HOLD;
          flush_q <= 1'b0;
          exc_q   <= EXCEPTION_NONE;
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            state_q <= ST_IDLE;
            stall_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
`ifdef TRAP_CTRL_WFI_EN
        ST_SLEEP: begin
          if (intr_any) begin
            cap_code_q <= EXCEPTION_INTERRUPT;
            cap_pc_q   <= bus.next_pc_i;
            cap_addr_q <= '0;
            cap_intr_q <= 1'b1;
            state_q    <= ST_DRAIN;
          end
        end
`endif
        default: begin
          state_q <= ST_IDLE;
          stall_q <= 1'b0;
          flush_q <= 1'b0;
          busy_q  <= 1'b0;
          exc_q   <= EXCEPTION_NONE;
        end
      endcase
    end
  end

`ifndef TRAP_CTRL_WFI_EN
  logic unused_wfi;
  assign unused_wfi = bus.wfi_i;
`endif

  assign bus.stall_o          = stall_q;
  assign bus.flush_o          = flush_q;
  assign bus.busy_o           = busy_q;
  assign bus.exception_o      = exc_q;
  assign bus.exception_pc_o   = exc_pc_q;
  assign bus.exception_addr_o = exc_addr_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed scenarios plus randomized traffic for trap_ctrl,
// checked every cycle against a transaction-level model (age since capture,
// drain length, settle window) and pinned by hand-computed expectations.
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  localparam int HOLDOFF   = 2;
  localparam int DRAIN_MAX = 64;
`ifdef TRAP_CTRL_WFI_EN
  localparam bit WFI_EN = 1'b1;
`else
  localparam bit WFI_EN = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  trap_ctrl_if bus();

  trap_ctrl #(.HOLDOFF(HOLDOFF), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // A sequence is described by its age (cycles since capture) and the age at
  // which draining ended; phase outputs follow from plain arithmetic on those.
  bit          m_active, m_sleep, m_cap_intr;
  int          m_age, m_drain_end;
  logic [5:0]  m_code;
  logic [31:0] m_pc, m_addr, m_last_pc, m_last_addr;

  task automatic model_reset();
    m_active = 0; m_sleep = 0; m_cap_intr = 0;
    m_age = 0; m_drain_end = 0;
    m_code = '0; m_pc = '0; m_addr = '0;
    m_last_pc = '0; m_last_addr = '0;
  endtask

  task automatic model_capture(input bit is_intr, input logic [5:0] code,
                               input logic [31:0] pc, input logic [31:0] addr);
    m_active = 1; m_age = 1; m_drain_end = 0;
    m_cap_intr = is_intr; m_code = code; m_pc = pc; m_addr = addr;
  endtask

  task automatic model_step();
    if (m_sleep) begin
      if (bus.intr_pending_i != 0) begin
        m_sleep = 0;
        model_capture(1, EXCEPTION_INTERRUPT, bus.next_pc_i, 32'h0);
      end
    end else if (!m_active) begin
      if (bus.exc_valid_i)
        model_capture(0, bus.exc_code_i, bus.exc_pc_i, bus.exc_addr_i);
      else if (bus.intr_pending_i != 0)
        model_capture(1, EXCEPTION_INTERRUPT, bus.next_pc_i, 32'h0);
      else if (WFI_EN && bus.wfi_i)
        m_sleep = 1;
    end else if (m_drain_end == 0) begin
      if (bus.pipe_idle_i || m_age == DRAIN_MAX) begin
        if (m_cap_intr && bus.intr_pending_i == 0) begin
          m_active = 0;
        end else begin
          m_drain_end = m_age;
          m_age++;
          m_last_pc = m_pc;
          m_last_addr = m_addr;
        end
      end else begin
        m_age++;
      end
    end else if (m_age == m_drain_end + 1 + HOLDOFF) begin
      m_active = 0;
    end else begin
      m_age++;
    end
  endtask

  function automatic bit m_busy();
    return m_active || m_sleep;
  endfunction

  function automatic bit m_issuing();
    return m_active && (m_drain_end != 0) && (m_age == m_drain_end + 1);
  endfunction

  task automatic compare_outputs();
    check("busy",  32'(bus.busy_o),  32'(m_busy()));
    check("stall", 32'(bus.stall_o), 32'(m_busy()));
    check("flush", 32'(bus.flush_o), 32'(m_issuing()));
    check("exception", 32'(bus.exception_o), m_issuing() ? 32'(m_code) : 32'(EXCEPTION_NONE));
    check("exception_pc",   bus.exception_pc_o,   m_last_pc);
    check("exception_addr", bus.exception_addr_o, m_last_addr);
  endtask

  // One clock: model advances on the edge, outputs compared mid-cycle.
  task automatic cycle();
    @(posedge clk);
    if (rstn) model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic quiet_inputs();
    bus.exc_valid_i = 0; bus.exc_code_i = '0; bus.exc_pc_i = '0; bus.exc_addr_i = '0;
    bus.intr_pending_i = '0; bus.next_pc_i = '0; bus.pipe_idle_i = 1; bus.wfi_i = 0;
  endtask

  // Asynchronous reset pulse from mid-cycle; outputs must clear immediately.
  task automatic do_reset(input string tag);
    #2 rstn = 0;
    model_reset();
    quiet_inputs();
    #1;
    check({tag, "_stall"}, 32'(bus.stall_o), 32'h0);
    check({tag, "_busy"},  32'(bus.busy_o),  32'h0);
    check({tag, "_flush"}, 32'(bus.flush_o), 32'h0);
    check({tag, "_exc"},   32'(bus.exception_o), 32'h0);
    check({tag, "_pc"},    bus.exception_pc_o,   32'h0);
    check({tag, "_addr"},  bus.exception_addr_o, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1;
  endtask

  // ---------------- directed scenario runner ----------------
  int          issue_cyc[$];
  logic [5:0]  issue_code[$];
  logic [31:0] issue_pc[$];
  logic [31:0] issue_addr[$];
  int          stall_cnt;

  task automatic run(input int n, input int idle_from, input int intr_drop_at,
                     input int intr_set_at, input logic [31:0] intr_set_val);
    issue_cyc.delete(); issue_code.delete(); issue_pc.delete(); issue_addr.delete();
    stall_cnt = 0;
    for (int i = 1; i <= n; i++) begin
      cycle();
      bus.exc_valid_i = 0;
      bus.wfi_i = 0;
      if (bus.stall_o) stall_cnt++;
      if (bus.flush_o) begin
        issue_cyc.push_back(i);
        issue_code.push_back(bus.exception_o);
        issue_pc.push_back(bus.exception_pc_o);
        issue_addr.push_back(bus.exception_addr_o);
      end
      bus.pipe_idle_i = (i >= idle_from);
      if (i == intr_drop_at) bus.intr_pending_i = '0;
      if (i == intr_set_at) bus.intr_pending_i = intr_set_val;
    end
  endtask

  task automatic check_issue(input string name, input int idx, input int exp_cyc,
                             input logic [5:0] exp_code, input logic [31:0] exp_pc);
    if (issue_cyc.size() > idx) begin
      check({name, "_cycle"}, issue_cyc[idx], exp_cyc);
      check({name, "_code"},  32'(issue_code[idx]), 32'(exp_code));
      check({name, "_pc"},    issue_pc[idx], exp_pc);
    end else begin
      check({name, "_present"}, issue_cyc.size(), idx + 1);
    end
  endtask

  task automatic settle();
    quiet_inputs();
    for (int i = 0; i < 8; i++) cycle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    quiet_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_stall", 32'(bus.stall_o), 32'h0);
    check("reset_busy",  32'(bus.busy_o),  32'h0);
    check("reset_flush", 32'(bus.flush_o), 32'h0);
    check("reset_exc",   32'(bus.exception_o), 32'h0);
    check("reset_pc",    bus.exception_pc_o,   32'h0);
    check("reset_addr",  bus.exception_addr_o, 32'h0);
    rstn = 1;
    cycle();

    // Illegal instruction, pipeline already idle.
    bus.exc_valid_i = 1; bus.exc_code_i = EXCEPTION_ILLEGAL_INSN;
    bus.exc_pc_i = 32'h100; bus.exc_addr_i = 32'hbad0_0013; bus.pipe_idle_i = 1;
    run(8, 0, 0, 0, 0);
    check("illegal_issues", issue_cyc.size(), 1);
    check_issue("illegal", 0, 2, 6'h12, 32'h100);
    check("illegal_stall_cycles", stall_cnt, 2 + HOLDOFF);
    settle();

    // Interrupt with a 5-cycle drain.
    bus.intr_pending_i = 32'h800; bus.next_pc_i = 32'h204; bus.pipe_idle_i = 0;
    run(12, 5, 6, 0, 0);
    check_issue("intr_drain", 0, 6, EXCEPTION_INTERRUPT, 32'h204);
    check("intr_drain_addr", issue_addr.size() > 0 ? issue_addr[0] : 32'hffff_ffff, 32'h0);
    check("intr_drain_stall_cycles", stall_cnt, 5 + 1 + HOLDOFF);
    settle();

    // MRET with a coincident interrupt: MRET first, interrupt after HOLD.
    bus.exc_valid_i = 1; bus.exc_code_i = EXCEPTION_ERET_M; bus.exc_pc_i = 32'h300;
    bus.exc_addr_i = 32'h0; bus.intr_pending_i = 32'h80; bus.next_pc_i = 32'h400;
    bus.pipe_idle_i = 1;
    run(12, 0, 7, 0, 0);
    check("mret_intr_issues", issue_cyc.size(), 2);
    check_issue("mret_first", 0, 2, EXCEPTION_ERET_M, 32'h300);
    check_issue("intr_second", 1, 2 + 1 + HOLDOFF + 2, EXCEPTION_INTERRUPT, 32'h400);
    settle();

    // Pipeline never drains: forced issue after DRAIN_MAX cycles.
    bus.exc_valid_i = 1; bus.exc_code_i = EXCEPTION_FENCE; bus.exc_pc_i = 32'h5a0;
    bus.exc_addr_i = 32'h1234; bus.pipe_idle_i = 0;
    run(70, 100000, 0, 0, 0);
    check_issue("forced", 0, 65, EXCEPTION_FENCE, 32'h5a0);
    check("forced_stall_cycles", stall_cnt, 64 + 1 + HOLDOFF);
    settle();

    // Interrupt withdrawn while draining: silent return to IDLE.
    bus.intr_pending_i = 32'h800; bus.next_pc_i = 32'h777; bus.pipe_idle_i = 0;
    run(8, 4, 2, 0, 0);
    check("abort_issues", issue_cyc.size(), 0);
    check("abort_stall_cycles", stall_cnt, 4);
    check("abort_exc", 32'(bus.exception_o), 32'h0);
    check("abort_busy", 32'(bus.busy_o), 32'h0);
    settle();

    // Reset while a request is draining discards it.
    bus.exc_valid_i = 1; bus.exc_code_i = EXCEPTION_ILLEGAL_INSN;
    bus.exc_pc_i = 32'h900; bus.pipe_idle_i = 0;
    run(3, 100000, 0, 0, 0);
    do_reset("rst_drain");
    settle();

`ifdef TRAP_CTRL_WFI_EN
    bus.wfi_i = 1; bus.next_pc_i = 32'h640;
    run(16, 0, 12, 10, 32'h80);
    check_issue("wfi_wake", 0, 12, EXCEPTION_INTERRUPT, 32'h640);
    check("wfi_stall_cycles", stall_cnt, 10 + 2 + HOLDOFF);
    settle();
    bus.wfi_i = 1;
    run(5, 0, 0, 0, 0);
    check("sleep_stall", 32'(bus.stall_o), 32'h1);
    do_reset("rst_sleep");
    settle();
`else
    bus.wfi_i = 1;
    run(4, 0, 0, 0, 0);
    check("wfi_ignored_stall_cycles", stall_cnt, 0);
    settle();
`endif

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset("rst_random");
      cycle();
      bus.exc_valid_i = 0;
      if (!m_busy() && $urandom_range(0, 3) == 0) begin
        bus.exc_valid_i = 1;
        case ($urandom_range(0, 3))
          0: bus.exc_code_i = EXCEPTION_ILLEGAL_INSN;
          1: bus.exc_code_i = EXCEPTION_ERET_M;
          2: bus.exc_code_i = EXCEPTION_FENCE;
          default: bus.exc_code_i = EXCEPTION_LOAD_FAULT;
        endcase
        bus.exc_pc_i = $urandom;
        bus.exc_addr_i = $urandom;
      end
      if ($urandom_range(0, 9) == 0)
        bus.intr_pending_i = (bus.intr_pending_i != 0) ? 32'h0 : (32'h1 << $urandom_range(0, 31));
      bus.pipe_idle_i = ($urandom_range(0, 2) == 0);
      bus.wfi_i = ($urandom_range(0, 7) == 0);
      bus.next_pc_i = $urandom;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the summary, limit 1000000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequences all trap-class events into the CSR register file: synchronous exceptions, interrupts, MRET and FENCE.
- Captures one request, stalls the front end, waits for the pipeline to drain, then issues a single-cycle exception code, PC and address to the CSR file.
- Asserts flush for the redirect and holds off new requests for a programmable settle period.
- Sits between the writeback/commit stage and the CSR file.

Parameters:
- HOLDOFF, 2, cycles spent in HOLD after ISSUE before new requests are accepted (1..15).
- DRAIN_MAX, 64, DRAIN cycle limit before forced issue (4..255).

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- exc_valid_i  in  1  commit stage presents a trap-class event this cycle
- exc_code_i  in  6  event code using shared define encodings (exception, ERET_M, FENCE)
- exc_pc_i  in  32  PC of the faulting/returning instruction
- exc_addr_i  in  32  faulting address / instruction bits
- intr_pending_i  in  32  masked pending interrupts from the CSR file
- next_pc_i  in  32  PC of the oldest unretired instruction (interrupt return point)
- pipe_idle_i  in  1  no instruction in flight past decode
- wfi_i  in  1  WFI retiring (optional feature only)
- stall_o  out  1  freeze fetch/decode
- flush_o  out  1  kill in-flight instructions, take CSR redirect
- exception_o  out  6  code to CSR file
- exception_pc_o  out  32  PC to CSR file
- exception_addr_o  out  32  address to CSR file
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset: state IDLE; stall_o=0, flush_o=0, busy_o=0; exception_o=EXCEPTION_NONE (0); exception_pc_o=0; exception_addr_o=0; counters 0.
- All outputs are registered or decoded from state only.
- IDLE, request selection:
  - exc_valid_i=1: capture code, exc_pc_i and exc_addr_i; go to DRAIN.
  - Else |intr_pending_i: capture EXCEPTION_INTERRUPT, next_pc_i and address 0; go to DRAIN.
  - Exception and interrupt in the same cycle: the exception wins. The interrupt stays pending and is re-sampled in IDLE after HOLD.
- DRAIN:
  - stall_o=1, busy_o=1.
  - Exit to ISSUE on the first cycle with pipe_idle_i=1. Minimum DRAIN residency is 1 cycle.
  - The drain counter increments each DRAIN cycle. Reaching DRAIN_MAX forces ISSUE regardless of pipe_idle_i.
  - An interrupt capture whose intr_pending_i has dropped to 0 by exit aborts to IDLE with no ISSUE.
- ISSUE: exactly one cycle.
  - exception_o, exception_pc_o and exception_addr_o hold the captured values; flush_o=1; stall_o=1.
  - Next state is HOLD.
- HOLD:
  - stall_o=1, flush_o=0, exception_o=0.
  - Counter loads HOLDOFF-1 and decrements; return to IDLE when it reaches 0. HOLDOFF=1 means one HOLD cycle.
- Requests outside IDLE are ignored; no queuing. exc_valid_i must not be asserted during stall.
- Request-to-issue latency: 2 cycles with pipe_idle_i already 1 (IDLE→DRAIN→ISSUE).
- busy_o=0 only in IDLE. Asynchronous reset mid-sequence returns to IDLE within the same cycle; a pending ISSUE is discarded.
- exception_pc_o and exception_addr_o retain their last issued values outside ISSUE.

Optional Feature:
- TRAP_CTRL_WFI_EN defined:
  - wfi_i in IDLE, with no exc_valid_i and intr_pending_i==0, enters SLEEP.
  - SLEEP: stall_o=1, busy_o=1.
  - Wake on |intr_pending_i: go directly to DRAIN with an EXCEPTION_INTERRUPT capture and PC next_pc_i.
- Undefined: wfi_i is ignored (treated as NOP), SLEEP does not exist, and the port remains but is unconnected internally.

Decomposition:
- State encoding (IDLE, DRAIN, ISSUE, HOLD, SLEEP) and EXCEPTION_NONE go in the shared define header, next to the existing exception codes.
- Exception codes are reused; none are redefined.
- One natural sub-module: trap_ctrl_cnt, a loadable down/up counter shared by DRAIN and HOLD.

Test Plan:
- Illegal instruction (code 0x12) at pc 0x100, pipe_idle_i=1:
  - ISSUE on cycle 2 with exception_o=0x12, exception_pc_o=0x100 and flush_o for 1 cycle.
  - stall_o held 2+HOLDOFF cycles total after DRAIN entry.
- intr_pending_i=0x800 with next_pc_i=0x204 and pipe_idle_i low for 5 cycles:
  - DRAIN lasts 5 cycles; then exception_o=EXCEPTION_INTERRUPT and exception_pc_o=0x204.
- exc_valid_i (MRET, ERET_M code) plus intr_pending_i=0x80 same cycle:
  - MRET issued first; the interrupt issues after HOLD expires.
- pipe_idle_i stuck 0:
  - Forced ISSUE after exactly DRAIN_MAX (64) DRAIN cycles.
- Interrupt captured, then intr_pending_i drops to 0 before drain completes:
  - Return to IDLE; no flush_o, exception_o stays 0.
- TRAP_CTRL_WFI_EN: wfi_i with no pending interrupts:
  - SLEEP with stall_o=1 for 10 cycles.
  - intr_pending_i=0x80 → DRAIN → ISSUE EXCEPTION_INTERRUPT.
  - rstn_i pulse during SLEEP → IDLE, all outputs 0.
